clause_register_file: RTL and testbench

CLAUSE_REGISTER_FILE -- requirements
Module: clause_register_file

---
 rtl/clause_register_file_if.sv | 44 ++++
 rtl/clause_register_file.sv | 124 ++++++++++++
 tb/tb_clause_register_file.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clause_register_file_if.sv
// Clause register file bus: write/invalidate port, scan control and
// streamed clause output with valid/ready handshake.
`ifndef BIT_WIDTH_OF_INTEGER_VARIABLE
`define BIT_WIDTH_OF_INTEGER_VARIABLE 8
`endif
`ifndef NUMBER_OF_INTEGER_VARIABLES
`define NUMBER_OF_INTEGER_VARIABLES 4
`endif

interface clause_register_file_if #(
    parameter int COEF_WIDTH = `BIT_WIDTH_OF_INTEGER_VARIABLE,
    parameter int NUM_VARS   = `NUMBER_OF_INTEGER_VARIABLES,
    parameter int DEPTH      = 8
);
    localparam int CW = COEF_WIDTH * NUM_VARS;
    localparam int AW = $clog2(DEPTH);

    logic          in_write_enable;
    logic [AW-1:0] in_write_address;
    logic [CW-1:0] in_clause_coefficients;
    logic          in_invalidate;
    logic          in_scan_start;
    logic          in_out_ready;
    logic [CW-1:0] out_clause_coefficients;
    logic [AW-1:0] out_clause_index;
    logic          out_valid;
    logic          out_scan_busy;
    logic          out_scan_done;
    logic [AW:0]   out_clause_count;

    modport master (
        output in_write_enable, in_write_address, in_clause_coefficients,
        output in_invalidate, in_scan_start, in_out_ready,
        input  out_clause_coefficients, out_clause_index, out_valid,
        input  out_scan_busy, out_scan_done, out_clause_count
    );

    modport slave (
        input  in_write_enable, in_write_address, in_clause_coefficients,
        input  in_invalidate, in_scan_start, in_out_ready,
        output out_clause_coefficients, out_clause_index, out_valid,
        output out_scan_busy, out_scan_done, out_clause_count
    );
endinterface

// File: rtl/clause_register_file.sv
// Clause store with per-entry valid bits and a scan engine that streams
// every valid entry in index order over a valid/ready output.
`ifndef BIT_WIDTH_OF_INTEGER_VARIABLE
`define BIT_WIDTH_OF_INTEGER_VARIABLE 8
`endif
`ifndef NUMBER_OF_INTEGER_VARIABLES
`define NUMBER_OF_INTEGER_VARIABLES 4
`endif

module clause_register_file #(
    parameter int COEF_WIDTH = `BIT_WIDTH_OF_INTEGER_VARIABLE,
    parameter int NUM_VARS   = `NUMBER_OF_INTEGER_VARIABLES,
    parameter int DEPTH      = 8
) (
    input logic                   in_clk,
    input logic                   in_reset_n,
    clause_register_file_if.slave bus
);
    localparam int CW = COEF_WIDTH * NUM_VARS;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid, valid_nxt;
    logic [AW:0]   count, count_nxt;
    logic [AW-1:0] ptr, ptr_nxt;
    logic [CW-1:0] word_q, word_nxt;
    logic [AW-1:0] idx_q, idx_nxt;
    logic          vld_q, vld_nxt;
    logic          done_q, done_nxt;
    logic          advance;

    assign advance = !vld_q || bus.in_out_ready;

    // Write wins over invalidate; count tracks valid-bit transitions only.
    always_comb begin
        valid_nxt = valid;
        count_nxt = count;
        if (bus.in_write_enable) begin
            valid_nxt[bus.in_write_address] = 1'b1;
            if (!valid[bus.in_write_address])
                count_nxt = count + 1'b1;
        end else if (bus.in_invalidate && valid[bus.in_write_address]) begin
            valid_nxt[bus.in_write_address] = 1'b0;
            count_nxt = count - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        word_nxt  = word_q;
        idx_nxt   = idx_q;
        vld_nxt   = vld_q;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                vld_nxt = 1'b0;
                if (bus.in_scan_start) begin
                    state_nxt = SCAN;
                    ptr_nxt   = '0;
                end
            end
            SCAN: begin
                if (advance) begin
                    vld_nxt = valid[ptr];
                    if (valid[ptr]) begin
                        word_nxt = mem[ptr];
                        idx_nxt  = ptr;
                    end
                    if (ptr == AW'(DEPTH - 1))
                        state_nxt = DRAIN;
                    else
                        ptr_nxt = ptr + 1'b1;
                end
            end
            DRAIN: begin
                if (advance) begin
                    vld_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage is not reset; valid bits hide stale contents.
    always_ff @(posedge in_clk) begin
        if (in_reset_n && bus.in_write_enable)
            mem[bus.in_write_address] <= bus.in_clause_coefficients;
    end

    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            state  <= IDLE;
            ptr    <= '0;
            valid  <= '0;
            count  <= '0;
            word_q <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            valid  <= valid_nxt;
            count  <= count_nxt;
            word_q <= word_nxt;
            idx_q  <= idx_nxt;
            vld_q  <= vld_nxt;
            done_q <= done_nxt;
        end
    end

    assign bus.out_clause_coefficients = word_q;
    assign bus.out_clause_index        = idx_q;
    assign bus.out_valid               = vld_q;
    assign bus.out_scan_busy           = (state != IDLE);
    assign bus.out_scan_done           = done_q;
    assign bus.out_clause_count        = count;
endmodule

// File: tb/tb_clause_register_file.sv
// Scoreboard bench for clause_register_file: expected stream entries are
// queued when a scan is set up and popped on each accepted output word.
module tb_clause_register_file;
    localparam int DEPTH = 8;
    localparam int CW    = 32;
    localparam int AW    = 3;

    typedef struct {
        logic [AW-1:0] idx;
        logic [CW-1:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clause_register_file_if #(
        .COEF_WIDTH(8), .NUM_VARS(4), .DEPTH(DEPTH)
    ) bus ();

    clause_register_file #(
        .COEF_WIDTH(8), .NUM_VARS(4), .DEPTH(DEPTH)
    ) dut (
        .in_clk    (clk),
        .in_reset_n(rst_n),
        .bus       (bus.slave)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   busy_cnt = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (bus.out_scan_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.out_scan_busy) busy_cnt++;
        if (rst_n && bus.out_valid && bus.in_out_ready) begin
            if (sb.size() == 0) begin
                check("extra_word", 64'(bus.out_clause_index) + 64'h100, 64'h0);
            end else begin
                e = sb.pop_front();
                check("stream_idx", 64'(bus.out_clause_index), 64'(e.idx));
                check("stream_word", 64'(bus.out_clause_coefficients), 64'(e.word));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input logic [CW-1:0] d);
        exp_t e;
        e.idx  = AW'(a);
        e.word = d;
        sb.push_back(e);
    endtask

    task automatic wr(input int a, input logic [CW-1:0] d);
        bus.in_write_enable        = 1'b1;
        bus.in_write_address       = AW'(a);
        bus.in_clause_coefficients = d;
        tick();
        bus.in_write_enable = 1'b0;
    endtask

    task automatic inv(input int a);
        bus.in_invalidate    = 1'b1;
        bus.in_write_address = AW'(a);
        tick();
        bus.in_invalidate = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    // Runs one scan; optional stall on one index and one write at offset wr_o.
    task automatic run_scan(input int stall_idx, input int stall_n,
                            input int wr_a, input int wr_o,
                            input logic [CW-1:0] wr_d,
                            input int exp_lat, input int exp_busy);
        int t;
        int d0;
        int b0;
        int stalls;
        d0 = done_cnt;
        b0 = busy_cnt;
        stalls = 0;
        bus.in_out_ready  = 1'b1;
        bus.in_scan_start = 1'b1;
        t = cyc;
        tick();
        bus.in_scan_start = 1'b0;
        while (done_cnt == d0 && (cyc - t) < 40) begin
            bus.in_write_enable = 1'b0;
            if (wr_a >= 0 && (cyc - t) == wr_o) begin
                bus.in_write_enable        = 1'b1;
                bus.in_write_address       = AW'(wr_a);
                bus.in_clause_coefficients = wr_d;
            end
            if (bus.out_valid && int'(bus.out_clause_index) == stall_idx
                && stalls < stall_n) begin
                bus.in_out_ready = 1'b0;
                stalls++;
                if (sb.size() == 0) begin
                    check("hold_sb", 64'h0, 64'h1);
                end else begin
                    check("hold_idx", 64'(bus.out_clause_index), 64'(sb[0].idx));
                    check("hold_word", 64'(bus.out_clause_coefficients),
                          64'(sb[0].word));
                end
            end else begin
                bus.in_out_ready = 1'b1;
            end
            tick();
        end
        bus.in_write_enable = 1'b0;
        bus.in_out_ready    = 1'b1;
        check("scan_done_seen", 64'(done_cnt - d0), 64'd1);
        check("done_latency", 64'(done_cyc - t), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt - b0), 64'(exp_busy));
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("idle_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int n;
        int d0;
        bus.in_write_enable        = 1'b0;
        bus.in_write_address       = '0;
        bus.in_clause_coefficients = '0;
        bus.in_invalidate          = 1'b0;
        bus.in_scan_start          = 1'b0;
        bus.in_out_ready           = 1'b1;

        // Reset overrides a write and a scan start in the same cycles
        bus.in_write_enable        = 1'b1;
        bus.in_write_address       = 3'd2;
        bus.in_clause_coefficients = 32'hDEAD;
        bus.in_scan_start          = 1'b1;
        tick();
        tick();
        bus.in_write_enable = 1'b0;
        bus.in_scan_start   = 1'b0;
        rst_n = 1'b1;
        check("rst_count", 64'(bus.out_clause_count), 64'd0);
        check("rst_busy", 64'(bus.out_scan_busy), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_done", 64'(bus.out_scan_done), 64'd0);
        check("rst_word", 64'(bus.out_clause_coefficients), 64'd0);
        check("rst_idx", 64'(bus.out_clause_index), 64'd0);

        // Entries 0,3,7 streamed in order, ready held high
        wr(0, 32'h1);
        wr(3, 32'h3);
        wr(7, 32'h7);
        check("fill_count", 64'(bus.out_clause_count), 64'd3);
        push(0, 32'h1);
        push(3, 32'h3);
        push(7, 32'h7);
        run_scan(-1, 0, -1, 0, '0, 10, 9);

        // Same fill, two stall cycles while index 3 is presented
        push(0, 32'h1);
        push(3, 32'h3);
        push(7, 32'h7);
        run_scan(3, 2, -1, 0, '0, 12, 11);

        // Write+invalidate acts as a write; repeated invalidate is a no-op
        bus.in_invalidate = 1'b1;
        wr(5, 32'h55);
        bus.in_invalidate = 1'b0;
        check("wi_count", 64'(bus.out_clause_count), 64'd4);
        wr(0, 32'h10);
        check("rewrite_count", 64'(bus.out_clause_count), 64'd4);
        inv(5);
        check("inv_count", 64'(bus.out_clause_count), 64'd3);
        inv(5);
        check("inv2_count", 64'(bus.out_clause_count), 64'd3);
        push(0, 32'h10);
        push(3, 32'h3);
        push(7, 32'h7);
        run_scan(-1, 0, -1, 0, '0, 10, 9);

        // Empty table still completes a scan
        do_reset();
        check("empty_count", 64'(bus.out_clause_count), 64'd0);
        run_scan(-1, 0, -1, 0, '0, 10, 9);

        // Reset in mid-scan aborts without a done pulse
        for (int i = 0; i < DEPTH; i++) begin
            wr(i, 32'(32'hA0 + i));
            push(i, 32'(32'hA0 + i));
        end
        check("full_count", 64'(bus.out_clause_count), 64'd8);
        d0 = done_cnt;
        bus.in_scan_start = 1'b1;
        tick();
        bus.in_scan_start = 1'b0;
        n = 0;
        while (!(bus.out_valid && bus.out_clause_index == 3'd4) && n < 30) begin
            tick();
            n++;
        end
        check("reach_idx4", 64'(n < 30), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        check("abort_valid", 64'(bus.out_valid), 64'd0);
        check("abort_busy", 64'(bus.out_scan_busy), 64'd0);
        check("abort_count", 64'(bus.out_clause_count), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_scan(-1, 0, -1, 0, '0, 10, 9);

        // Writes racing the scan pointer
        do_reset();
        wr(1, 32'h11);
        wr(6, 32'h66);
        push(1, 32'h11);
        push(6, 32'hA6);
        run_scan(-1, 0, 6, 3, 32'hA6, 10, 9);
        push(1, 32'h11);
        push(6, 32'hA6);
        run_scan(-1, 0, 1, 3, 32'hB1, 10, 9);
        push(1, 32'hB1);
        push(6, 32'hA6);
        run_scan(-1, 0, 2, 3, 32'h22, 10, 9);
        check("race_count", 64'(bus.out_clause_count), 64'd3);
        push(1, 32'hB1);
        push(2, 32'h22);
        push(6, 32'hA6);
        run_scan(-1, 0, -1, 0, '0, 10, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
